// File: rtl/instruction_fetch_buffer_pkg.sv
// rtl/instruction_fetch_buffer_pkg.sv - shared types and constants for the fetch buffer (optional feature macro: IFB_BYPASS_EN)
package jups_fetch_pkg;

    localparam int IFB_DEPTH  = 4;
    localparam int IFB_ADDR_W = 32;
    localparam int IFB_DATA_W = 32;

    // Pointer width: one wrap bit above the ring index
    localparam int PTR_W = $clog2(IFB_DEPTH) + 1;

    // Content loaded into every ring slot on reset
    localparam logic [IFB_DATA_W-1:0] NOP_INSTR = 32'h0;

    typedef struct packed {
        logic [IFB_ADDR_W-1:0] pc;
        logic [IFB_DATA_W-1:0] instr;
    } fetch_entry_t;

    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/instruction_fetch_buffer_ring.sv
// rtl/instruction_fetch_buffer_ring.sv - fetch ring storage with separate pc and instr write ports (optional feature macro: IFB_BYPASS_EN)
module ifb_ring
    import jups_fetch_pkg::*;
#(
    parameter int DEPTH  = IFB_DEPTH,
    parameter int ADDR_W = IFB_ADDR_W,
    parameter int DATA_W = IFB_DATA_W,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              i_pc_we,
    input  logic [IDX_W-1:0]  i_pc_widx,
    input  logic [ADDR_W-1:0] i_pc_wdata,
    input  logic              i_instr_we,
    input  logic [IDX_W-1:0]  i_instr_widx,
    input  logic [DATA_W-1:0] i_instr_wdata,
    input  logic [IDX_W-1:0]  i_rd_idx,
    output logic [ADDR_W-1:0] o_rd_pc,
    output logic [DATA_W-1:0] o_rd_instr
);

    logic [ADDR_W-1:0] r_pc    [DEPTH];
    logic [DATA_W-1:0] r_instr [DEPTH];

    // pc half of each slot is written when the request is granted
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pc[i] <= '0;
            end
        end else if (i_pc_we) begin
            r_pc[i_pc_widx] <= i_pc_wdata;
        end
    end

    // instr half of each slot is written when the matching response returns
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_instr[i] <= DATA_W'(NOP_INSTR);
            end
        end else if (i_instr_we) begin
            r_instr[i_instr_widx] <= i_instr_wdata;
        end
    end

    assign o_rd_pc    = r_pc[i_rd_idx];
    assign o_rd_instr = r_instr[i_rd_idx];

endmodule

// File: rtl/instruction_fetch_buffer.sv
// rtl/instruction_fetch_buffer.sv - in-order fetch issue, response ring and decode handshake (optional feature macro: IFB_BYPASS_EN)
module instruction_fetch_buffer
    import jups_fetch_pkg::*;
#(
    parameter int DEPTH  = IFB_DEPTH,
    parameter int ADDR_W = IFB_ADDR_W,
    parameter int DATA_W = IFB_DATA_W
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              flush,
    output logic              pc_halt,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [DATA_W-1:0] if_instr,
    output logic [ADDR_W-1:0] if_pc
);

    localparam int            PW      = ptr_width(DEPTH);
    localparam int            IW      = PW - 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0] ONE     = PW'(1);

    // Responses come back in order, so new requests may go out while stale ones drain
    localparam logic DISCARD_OVERLAP = 1'b1;

    logic [PW-1:0]     r_alloc;
    logic [PW-1:0]     r_fill;
    logic [PW-1:0]     r_rd;
    logic [PW-1:0]     r_discard;

    logic [PW-1:0]     w_used;
    logic [PW-1:0]     w_unfilled;
    logic [PW-1:0]     w_discard_next;
    logic              w_room;
    logic              w_discard_zero;
    logic              w_issue;
    logic              w_resp_live;
    logic              w_resp_drop;
    logic              w_ring_empty;
    logic              w_bypass;
    logic              w_rd_fire;
    logic              w_flush_sub;
    logic              w_instr_we;
    logic [ADDR_W-1:0] w_rd_pc;
    logic [DATA_W-1:0] w_rd_instr;

    // Occupancy counts use only registered pointers, so a same-cycle read never frees a slot early
    assign w_used         = r_alloc - r_rd;
    assign w_unfilled     = r_alloc - r_fill;
    assign w_room         = (w_used < DEPTH_P);
    assign w_discard_zero = (r_discard == '0);
    assign w_ring_empty   = (r_rd == r_fill);

    // Reset_n gates the request so the PC is held while the block is in reset
    assign mem_req  = Reset_n && !flush && w_room && (w_discard_zero || DISCARD_OVERLAP);
    assign mem_addr = pc_in;
    assign w_issue  = mem_req && mem_gnt;
    assign pc_halt  = !w_issue;

    // A response with nothing outstanding and nothing to discard is ignored
    assign w_resp_live = mem_rvalid && w_discard_zero && (w_unfilled != '0);
    assign w_resp_drop = mem_rvalid && !w_discard_zero;

    // On a flush the word returning this cycle is dropped, whether stale or live
    assign w_flush_sub = mem_rvalid && (!w_discard_zero || (w_unfilled != '0));
    assign w_instr_we  = w_resp_live && !flush;

`ifdef IFB_BYPASS_EN
    // Empty ring: a live response goes straight to decode; rd == fill so the slot pc is ring[rd].pc
    assign w_bypass = Reset_n && w_ring_empty && w_resp_live;
`else
    assign w_bypass = 1'b0;
`endif

    assign if_valid  = Reset_n && (!w_ring_empty || w_bypass);
    assign if_instr  = w_bypass ? mem_rdata : w_rd_instr;
    assign if_pc     = w_rd_pc;
    assign w_rd_fire = if_valid && if_ready;

    // Outstanding stale responses: grows by the unfilled entries on a flush, shrinks per dropped word
    always_comb begin
        w_discard_next = r_discard;
        if (flush) begin
            w_discard_next = r_discard + w_unfilled - PW'(w_flush_sub);
        end else if (w_resp_drop) begin
            w_discard_next = r_discard - ONE;
        end
    end

    // Ring pointers: flush abandons every entry, otherwise issue, fill and read advance independently
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_alloc <= '0;
            r_fill  <= '0;
            r_rd    <= '0;
        end else if (flush) begin
            r_alloc <= '0;
            r_fill  <= '0;
            r_rd    <= '0;
        end else begin
            r_alloc <= r_alloc + PW'(w_issue);
            r_fill  <= r_fill + PW'(w_resp_live);
            r_rd    <= r_rd + PW'(w_rd_fire);
        end
    end

    // Discard counter register
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_discard <= '0;
        end else begin
            r_discard <= w_discard_next;
        end
    end

    ifb_ring #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ring (
        .Clock         (Clock),
        .Reset_n       (Reset_n),
        .i_pc_we       (w_issue),
        .i_pc_widx     (r_alloc[IW-1:0]),
        .i_pc_wdata    (pc_in),
        .i_instr_we    (w_instr_we),
        .i_instr_widx  (r_fill[IW-1:0]),
        .i_instr_wdata (mem_rdata),
        .i_rd_idx      (r_rd[IW-1:0]),
        .o_rd_pc       (w_rd_pc),
        .o_rd_instr    (w_rd_instr)
    );

endmodule

// File: tb/tb_instruction_fetch_buffer.sv
// tb/tb_instruction_fetch_buffer.sv - scoreboard bench for instruction_fetch_buffer with a randomized memory and PC model
module tb_instruction_fetch_buffer;
    import jups_fetch_pkg::*;

    localparam int D  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
`ifdef IFB_BYPASS_EN
    localparam int FIRST_LAT = 1;
`else
    localparam int FIRST_LAT = 2;
`endif

    logic          Clock = 1'b0;
    logic          Reset_n;
    logic [AW-1:0] pc_in;
    logic          flush;
    logic          pc_halt;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_gnt;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;
    logic          if_valid;
    logic          if_ready;
    logic [DW-1:0] if_instr;
    logic [AW-1:0] if_pc;

    instruction_fetch_buffer #(.DEPTH(D), .ADDR_W(AW), .DATA_W(DW)) dut (
        .Clock      (Clock),
        .Reset_n    (Reset_n),
        .pc_in      (pc_in),
        .flush      (flush),
        .pc_halt    (pc_halt),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .if_valid   (if_valid),
        .if_ready   (if_ready),
        .if_instr   (if_instr),
        .if_pc      (if_pc)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [AW-1:0] addr;
        int            due;
    } mreq_t;

    int            total = 0;
    int            bad   = 0;
    int            cyc   = 0;
    mreq_t         mem_q [$];
    fetch_entry_t  exp_q [$];
    logic [AW-1:0] dlv_pc [$];
    int            dlv_cyc [$];
    logic [AW-1:0] gnt_addr [$];

    int            rdy_pct = 100;
    int            gnt_pct = 100;
    int            rv_pct  = 100;
    int            lat_min = 1;
    int            lat_max = 1;
    bit            flush_now = 1'b0;
    logic [AW-1:0] flush_tgt = '0;
    logic [AW-1:0] pc_m = '0;
    logic          s_req, s_halt, s_valid;

    function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    // One clock cycle of memory, PC and decode environment; called at posedge+1
    task automatic cycle();
        mreq_t        m;
        fetch_entry_t e;
        pc_in    = pc_m;
        flush    = flush_now;
        if_ready = ($urandom_range(99) < rdy_pct);
        mem_gnt  = ($urandom_range(99) < gnt_pct);
        if (mem_q.size() != 0 && cyc >= mem_q[0].due && $urandom_range(99) < rv_pct) begin
            mem_rvalid = 1'b1;
            mem_rdata  = word_of(mem_q[0].addr);
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
        end
        @(negedge Clock);
        #1;
        s_req   = mem_req;
        s_halt  = pc_halt;
        s_valid = if_valid;
        if (mem_req && mem_gnt) begin
            m.addr = mem_addr;
            m.due  = cyc + int'($urandom_range(lat_max, lat_min));
            mem_q.push_back(m);
            e.pc    = pc_m;
            e.instr = word_of(pc_m);
            exp_q.push_back(e);
            gnt_addr.push_back(mem_addr);
        end
        if (mem_rvalid) void'(mem_q.pop_front());
        if (flush) begin
            exp_q.delete();
            pc_m      = flush_tgt;
            flush_now = 1'b0;
        end else if (!pc_halt) begin
            pc_m = pc_m + 1;
        end
        @(posedge Clock);
        #1;
        cyc++;
    endtask

    task automatic drain();
        gnt_pct = 0;
        rdy_pct = 100;
        rv_pct  = 100;
        repeat (40) cycle();
        chk("drain_scoreboard_empty", exp_q.size(), 0);
        chk("drain_if_valid", s_valid, 0);
    endtask

    // Monitor: every decode handshake pops the scoreboard and is compared
    always @(negedge Clock) begin : mon
        fetch_entry_t e;
        if (Reset_n === 1'b1) begin
            if (mem_rvalid) assert (mem_q.size() != 0) else $error("protocol: response with nothing outstanding");
            if (if_valid) begin
                chk("valid_has_expected", exp_q.size() != 0, 1);
                if (if_ready && exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("if_pc", if_pc, e.pc);
                    chk("if_instr", if_instr, e.instr);
                    dlv_pc.push_back(if_pc);
                    dlv_cyc.push_back(cyc);
                end
            end
        end
    end

    initial begin
        Reset_n = 1'b0; flush = 1'b0; pc_in = '0; if_ready = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge Clock);
        #1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_if_valid", if_valid, 0);
        chk("rst_if_instr", if_instr, 0);
        chk("rst_if_pc", if_pc, 0);
        chk("rst_pc_halt", pc_halt, 1);

        // streaming from pc 0, 1-cycle memory, always ready
        Reset_n = 1'b1;
        pc_m = '0;
        repeat (12) cycle();
        chk("stream_count", dlv_pc.size() >= 4, 1);
        if (dlv_pc.size() >= 4) begin
            chk("stream_first_latency", dlv_cyc[0], FIRST_LAT);
            for (int i = 0; i < 4; i++) begin
                chk("stream_pc", dlv_pc[i], i);
                if (i > 0) chk("stream_back_to_back", dlv_cyc[i] - dlv_cyc[i-1], 1);
            end
        end
        chk("stream_pc_halt", s_halt, 0);

        // back-pressure: ring fills after four grants and the PC freezes at 4
        rdy_pct = 0; flush_now = 1'b1; flush_tgt = '0;
        cycle();
        gnt_addr.delete(); dlv_pc.delete();
        repeat (10) cycle();
        chk("bp_grants", gnt_addr.size(), 4);
        chk("bp_mem_req", s_req, 0);
        chk("bp_pc_halt", s_halt, 1);
        chk("bp_pc_frozen", mem_addr, 4);
        rdy_pct = 100; gnt_addr.delete();
        repeat (10) cycle();
        chk("bp_resume_any", gnt_addr.size() != 0, 1);
        if (gnt_addr.size() != 0) chk("bp_resume_addr", gnt_addr[0], 4);
        chk("bp_delivered", dlv_pc.size() >= 5, 1);
        if (dlv_pc.size() >= 5) for (int i = 0; i < 5; i++) chk("bp_order", dlv_pc[i], i);

        // flush with three requests in flight
        drain();
        gnt_pct = 100; lat_min = 8; lat_max = 8;
        flush_now = 1'b1; flush_tgt = 32'h8;
        cycle();
        gnt_addr.delete();
        repeat (3) cycle();
        chk("fl_inflight", gnt_addr.size(), 3);
        dlv_pc.delete();
        flush_now = 1'b1; flush_tgt = 32'h40;
        cycle();
        cycle();
        chk("fl_idle_after", s_valid, 0);
        repeat (30) cycle();
        chk("fl_delivered", dlv_pc.size() != 0, 1);
        if (dlv_pc.size() != 0) chk("fl_first_pc", dlv_pc[0], 32'h40);

        // flush in the same cycle as a response, two in flight
        drain();
        gnt_pct = 100; lat_min = 2; lat_max = 2;
        flush_now = 1'b1; flush_tgt = 32'h100;
        cycle();
        cycle();
        cycle();
        flush_now = 1'b1; flush_tgt = 32'h200;
        cycle();
        dlv_pc.delete();
        repeat (20) cycle();
        chk("flrv_delivered", dlv_pc.size() != 0, 1);
        if (dlv_pc.size() != 0) chk("flrv_first_pc", dlv_pc[0], 32'h200);

        // asynchronous reset mid-stream
        drain();
        gnt_pct = 100; lat_min = 1; lat_max = 1; rdy_pct = 0;
        flush_now = 1'b1; flush_tgt = 32'h300;
        cycle();
        repeat (4) cycle();
        chk("mr_valid_before", s_valid, 1);
        #3;
        Reset_n = 1'b0;
        #1;
        chk("mr_if_valid", if_valid, 0);
        chk("mr_mem_req", mem_req, 0);
        chk("mr_pc_halt", pc_halt, 1);
        exp_q.delete(); mem_q.delete(); mem_rvalid = 1'b0;
        @(posedge Clock);
        #1;
        Reset_n = 1'b1; pc_m = 32'h500; rdy_pct = 100;
        dlv_pc.delete(); gnt_addr.delete();
        repeat (10) cycle();
        chk("mr_restart_grant", gnt_addr.size() != 0, 1);
        if (gnt_addr.size() != 0) chk("mr_restart_addr", gnt_addr[0], 32'h500);
        chk("mr_restart_dlv", dlv_pc.size() != 0, 1);
        if (dlv_pc.size() != 0) chk("mr_restart_pc", dlv_pc[0], 32'h500);

        // randomized traffic with occasional redirects
        for (int blk = 0; blk < 60; blk++) begin
            rdy_pct = $urandom_range(100, 20);
            gnt_pct = $urandom_range(100, 20);
            rv_pct  = $urandom_range(100, 20);
            lat_min = 1;
            lat_max = $urandom_range(6, 1);
            repeat (50) begin
                if (!flush_now && mem_q.size() <= 2*D-1 && $urandom_range(99) < 3) begin
                    flush_now = 1'b1;
                    flush_tgt = $urandom;
                end
                cycle();
            end
        end
        drain();
        chk("final_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
